// File: rtl/apb_alu_pkg.sv
// Shared types and constants for the APB ALU scheduler: FSM/step encodings,
// slave register offsets, opcode enum and the latched job payload.
package apb_alu_pkg;

    localparam int unsigned ALU_DW = 16;

    localparam logic [31:0] ALU_OPS_OFS   = 32'h0000_0000;
    localparam logic [31:0] ALU_CMD_OFS   = 32'h0000_0004;
    localparam logic [31:0] ALU_RES_OFS   = 32'h0000_0008;
    localparam logic [15:0] ALU_VALID_SET = 16'h0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_RESP
    } state_e;

    // STEP_CLR_CMD is only reachable when the poll timeout is compiled in
    typedef enum logic [2:0] {
        STEP_WR_OPS,
        STEP_WR_CMD,
        STEP_RD_STAT,
        STEP_RD_RES,
        STEP_CLR_CMD
    } step_e;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR
    } alu_op_e;

    typedef struct packed {
        logic [ALU_DW-1:0] b;
        logic [ALU_DW-1:0] a;
        alu_op_e           op;
    } alu_job_t;

    function automatic logic [31:0] step_ofs(input step_e s);
        case (s)
            STEP_WR_OPS: step_ofs = ALU_OPS_OFS;
            STEP_RD_RES: step_ofs = ALU_RES_OFS;
            default:     step_ofs = ALU_CMD_OFS;
        endcase
    endfunction

    function automatic logic step_is_write(input step_e s);
        step_is_write = (s == STEP_WR_OPS) || (s == STEP_WR_CMD) || (s == STEP_CLR_CMD);
    endfunction

endpackage

// File: rtl/apb_alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr,
// searching cyclically.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDW-1:0]     grant_idx_c
);

    function automatic int unsigned wrap_idx(input logic [IDW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        wrap_idx = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    endfunction

    // Walk from the farthest offset down so the nearest requester wins last
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        if (enable) begin
            for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
                if (req[IDW'(wrap_idx(ptr, 32'(k)))]) begin
                    grant_c                                  = '0;
                    grant_c[IDW'(wrap_idx(ptr, 32'(k)))]     = 1'b1;
                    grant_idx_c                              = IDW'(wrap_idx(ptr, 32'(k)));
                end
            end
        end
    end

endmodule

// File: rtl/apb_alu_sched.sv
// Round-robin APB master sharing one ALU slave between NUM_REQ requesters.
// Optional poll timeout: define APB_ALU_SCHED_TIMEOUT_EN.
module apb_alu_sched
    import apb_alu_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned POLL_LIMIT = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [16*NUM_REQ-1:0]       req_a,
    input  logic [16*NUM_REQ-1:0]       req_b,
    input  logic [2*NUM_REQ-1:0]        req_op,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [15:0]                 rsp_result,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [31:0]                 PADDR,
    output logic [3:0]                  PSTRB,
    output logic [31:0]                 PWDATA,
    input  logic [31:0]                 PRDATA,
    input  logic                        PREADY
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned DW  = ALU_DW;

    state_e               state, state_n;
    step_e                step, step_n;
    alu_job_t             job_q, job_c;
    logic [IDW-1:0]       id_q, rr_ptr;
    logic [31:0]          rdata_q;
    logic [NUM_REQ-1:0]   arb_grant_c;
    logic [IDW-1:0]       arb_idx_c;
    logic                 arb_en_c, take_c, poll_expired_c;
    int unsigned          sel_c;

    logic [NUM_REQ-1:0]   grant_n;
    logic                 rsp_valid_n, busy_n, psel_n, penable_n, pwrite_n;
    logic [IDW-1:0]       rsp_id_n;
    logic [15:0]          rsp_result_n;
    logic [31:0]          paddr_n, pwdata_n;

    assign PSTRB = 4'hF;

    // A new job may be taken from IDLE (nothing pending) or straight out of RESP
    assign arb_en_c = ((state == S_IDLE) && !(|req_grant)) || (state == S_RESP);
    assign take_c   = |arb_grant_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .enable      (arb_en_c),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c)
    );

    always_comb begin
        sel_c    = 32'(arb_idx_c);
        job_c.a  = req_a[DW*sel_c +: DW];
        job_c.b  = req_b[DW*sel_c +: DW];
        job_c.op = alu_op_e'(req_op[2*sel_c +: 2]);
    end

`ifdef APB_ALU_SCHED_TIMEOUT_EN
    localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] poll_cnt;
    logic           rsp_err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            poll_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (take_c)
                poll_cnt <= '0;
            else if ((state == S_GAP) && (step == STEP_RD_STAT))
                poll_cnt <= poll_cnt + PCW'(1);
            rsp_err_q <= (state == S_GAP) && (step == STEP_CLR_CMD);
        end
    end

    assign poll_expired_c = (32'(poll_cnt) + 32'd1) >= POLL_LIMIT;
    assign rsp_err        = rsp_err_q;
`else
    logic unused_poll_limit;
    assign unused_poll_limit = ^POLL_LIMIT;
    assign poll_expired_c    = 1'b0;
    assign rsp_err           = 1'b0;
`endif

    // Next state, and next values of every registered output
    always_comb begin
        state_n      = state;
        step_n       = step;
        grant_n      = take_c ? arb_grant_c : '0;
        rsp_result_n = '0;

        case (state)
            S_IDLE: begin
                if (|req_grant) begin
                    state_n = S_SETUP;
                    step_n  = STEP_WR_OPS;
                end
            end
            S_SETUP:  state_n = S_ACCESS;
            S_ACCESS: if (PREADY) state_n = S_GAP;
            S_GAP: begin
                state_n = S_SETUP;
                case (step)
                    STEP_WR_OPS: step_n = STEP_WR_CMD;
                    STEP_WR_CMD: step_n = STEP_RD_STAT;
                    STEP_RD_STAT: begin
                        if (rdata_q[31:16] == 16'h0)
                            step_n = STEP_RD_RES;
                        else if (poll_expired_c)
                            step_n = STEP_CLR_CMD;
                    end
                    STEP_RD_RES: begin
                        state_n      = S_RESP;
                        rsp_result_n = rdata_q[15:0];
                    end
                    default: state_n = S_RESP;
                endcase
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        rsp_valid_n = (state_n == S_RESP);
        rsp_id_n    = rsp_valid_n ? id_q : '0;
        busy_n      = take_c || (state_n != S_IDLE);
        psel_n      = (state_n == S_SETUP) || (state_n == S_ACCESS);
        penable_n   = (state_n == S_ACCESS);
        pwrite_n    = psel_n && step_is_write(step_n);
        paddr_n     = psel_n ? (BASE_ADDR + step_ofs(step_n)) : 32'h0;
        pwdata_n    = 32'h0;
        if (pwrite_n) begin
            case (step_n)
                STEP_WR_OPS: pwdata_n = {job_q.b, job_q.a};
                STEP_WR_CMD: pwdata_n = {ALU_VALID_SET, 14'b0, job_q.op};
                default:     pwdata_n = 32'h0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= S_IDLE;
            step       <= STEP_WR_OPS;
            job_q      <= '0;
            id_q       <= '0;
            rr_ptr     <= '0;
            rdata_q    <= '0;
            req_grant  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            busy       <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (take_c) begin
                job_q  <= job_c;
                id_q   <= arb_idx_c;
                rr_ptr <= (32'(arb_idx_c) == NUM_REQ - 1) ? '0 : arb_idx_c + IDW'(1);
            end
            if ((state == S_ACCESS) && PREADY)
                rdata_q <= PRDATA;
            req_grant  <= grant_n;
            rsp_valid  <= rsp_valid_n;
            rsp_id     <= rsp_id_n;
            rsp_result <= rsp_result_n;
            busy       <= busy_n;
            PSEL       <= psel_n;
            PENABLE    <= penable_n;
            PWRITE     <= pwrite_n;
            PADDR      <= paddr_n;
            PWDATA     <= pwdata_n;
        end
    end

endmodule

// File: tb/tb_apb_alu_sched.sv
// Directed bench for apb_alu_sched with a behavioural ALU slave stub
// (configurable wait states and number of busy status polls).
module tb_apb_alu_sched;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_op = '0;
    logic [1:0]  req_grant;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    apb_alu_sched #(.NUM_REQ(2), .BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave stub configuration and transfer log
    int          cfg_wait = 1;
    int          cfg_hold = 0;
    int          wcnt = 0;
    int          n_xfer = 0;
    logic        log_wr   [0:255];
    logic [31:0] log_addr [0:255];
    logic [31:0] log_data [0:255];
    logic [15:0] s_a = '0, s_b = '0, s_res = '0;
    logic [1:0]  s_op = '0;
    logic        s_valid = 1'b0;
    int          s_polls = 0;
    logic        after_done = 1'b0;
    int          gap_viol = 0;
    int          overlap = 0;

    always @(negedge PCLK) begin
        if (after_done && PSEL) gap_viol++;
        if ((req_grant != 2'b00) && rsp_valid) overlap++;
        if (PSEL && PENABLE) begin
            if (wcnt < cfg_wait) begin
                wcnt++;
                PREADY = 1'b0;
            end else begin
                PREADY = 1'b1;
                wcnt   = 0;
                if (n_xfer < 256) begin
                    log_wr[n_xfer]   = PWRITE;
                    log_addr[n_xfer] = PADDR;
                    log_data[n_xfer] = PWRITE ? PWDATA : 32'h0;
                end
                n_xfer++;
                PRDATA = 32'h0;
                if (PWRITE) begin
                    if (PADDR == BASE) begin
                        s_a = PWDATA[15:0];
                        s_b = PWDATA[31:16];
                    end else if (PADDR == BASE + 32'h4) begin
                        s_op    = PWDATA[1:0];
                        s_valid = (PWDATA[31:16] != 16'h0);
                        s_polls = cfg_hold;
                        case (PWDATA[1:0])
                            2'd0: s_res = s_a + s_b;
                            2'd1: s_res = s_a - s_b;
                            2'd2: s_res = s_a & s_b;
                            default: s_res = s_a | s_b;
                        endcase
                    end
                end else if (PADDR == BASE + 32'h4) begin
                    if (s_valid && s_polls > 0) begin
                        s_polls--;
                        PRDATA = {16'h0001, 14'b0, s_op};
                    end else begin
                        s_valid = 1'b0;
                        PRDATA  = {16'h0000, 14'b0, s_op};
                    end
                end else if (PADDR == BASE + 32'h8) begin
                    PRDATA = {16'h0, s_res};
                end
            end
        end else begin
            PREADY = 1'b0;
            wcnt   = 0;
        end
        after_done = PRESETn && PSEL && PENABLE && PREADY;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int count_stat(input int b);
        int n = 0;
        for (int i = b; i < n_xfer && i < 256; i++)
            if (!log_wr[i] && log_addr[i] == BASE + 32'h4) n++;
        return n;
    endfunction

    // Issue one job from requester id and check grant, response and latency
    task automatic do_job(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input int hold, input int waits,
                          input logic [15:0] exp_res, input logic exp_err,
                          input int exp_lat, input int exp_xfers, output int base);
        int  t_g;
        bit  got;
        cfg_hold = hold;
        cfg_wait = waits;
        base     = n_xfer;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_op[2*id +: 2]  = op;
        req_valid[id]      = 1'b1;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (req_grant != 2'b00) begin got = 1; break; end
        end
        check("grant_seen", 32'(got), 32'd1);
        check("grant_onehot", 32'(req_grant), 32'(1 << id));
        check("busy_at_grant", 32'(busy), 32'd1);
        t_g = cyc;
        req_valid[id] = 1'b0;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin got = 1; break; end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_result", 32'(rsp_result), 32'(exp_res));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("latency", 32'(cyc - t_g), 32'(exp_lat));
        check("xfer_count", 32'(n_xfer - base), 32'(exp_xfers));
        @(negedge PCLK);
        check("idle_after_rsp", {30'b0, busy, PSEL}, 32'd0);
    endtask

    int  b0;
    int  ng, nr, last_r;
    bit  got;
    logic [1:0] gid [0:3];

    initial begin
        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_ctrl", {25'b0, req_grant, rsp_valid, busy, PSEL, PENABLE, PWRITE}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp", {15'b0, rsp_err, rsp_result}, 32'd0);
        check("rst_pstrb", 32'(PSTRB), 32'hF);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Single add job: 5 + 3
        do_job(0, 16'd5, 16'd3, 2'd0, 0, 1, 16'd8, 1'b0, 17, 4, b0);
        check("x0", {31'b0, log_wr[b0]},   32'd1);
        check("x0_addr", log_addr[b0],     BASE);
        check("x0_data", log_data[b0],     32'h0003_0005);
        check("x1_addr", log_addr[b0+1],   BASE + 32'h4);
        check("x1_data", log_data[b0+1],   32'h0001_0000);
        check("x2_rd",   {31'b0, log_wr[b0+2]}, 32'd0);
        check("x2_addr", log_addr[b0+2],   BASE + 32'h4);
        check("x3_rd",   {31'b0, log_wr[b0+3]}, 32'd0);
        check("x3_addr", log_addr[b0+3],   BASE + 32'h8);

        // Subtraction wrapping below zero
        do_job(1, 16'd2, 16'd5, 2'd1, 0, 1, 16'hFFFD, 1'b0, 17, 4, b0);

        // Both requesters continuously: 0,1,0,1 with back-to-back grants
        cfg_hold  = 0;
        cfg_wait  = 1;
        req_a     = {16'd6, 16'd7};
        req_b     = {16'd3, 16'd1};
        req_op    = {2'd3, 2'd2};
        req_valid = 2'b11;
        ng = 0; nr = 0; last_r = 0;
        for (int i = 0; i < 300 && nr < 4; i++) begin
            @(negedge PCLK);
            if (req_grant != 2'b00 && ng < 4) begin
                gid[ng] = req_grant;
                check("rr_after_rsp", 32'(nr), 32'(ng));
                if (ng > 0) check("rr_b2b", 32'(cyc - last_r), 32'd1);
                ng++;
                if (ng == 4) req_valid = 2'b00;
            end
            if (rsp_valid) begin
                nr++;
                last_r = cyc;
                check("rr_id", 32'(rsp_id), 32'((nr - 1) % 2));
                check("rr_res", 32'(rsp_result), rsp_id ? 32'd7 : 32'd1);
            end
        end
        check("rr_rsp_count", 32'(nr), 32'd4);
        check("rr_g0", 32'(gid[0]), 32'd1);
        check("rr_g1", 32'(gid[1]), 32'd2);
        check("rr_g2", 32'(gid[2]), 32'd1);
        check("rr_g3", 32'(gid[3]), 32'd2);
        @(negedge PCLK);

        // Slave busy for two polls, three wait states per access
        do_job(0, 16'd9, 16'd4, 2'd1, 2, 3, 16'd5, 1'b0, 37, 6, b0);
        check("stat_reads", 32'(count_stat(b0)), 32'd3);
        check("last_is_res", log_addr[b0+5], BASE + 32'h8);

        // Reset while the first transfer is in its access phase
        cfg_wait = 3;
        req_a[31:16] = 16'd1; req_b[31:16] = 16'd1; req_op[3:2] = 2'd0;
        req_valid = 2'b10;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (req_grant != 2'b00) req_valid = 2'b00;
            if (PENABLE) begin got = 1; break; end
        end
        check("rst_reach_access", 32'(got), 32'd1);
        req_valid = 2'b00;
        PRESETn = 1'b0;
        #1;
        check("midrst_ctrl", {25'b0, req_grant, rsp_valid, busy, PSEL, PENABLE, PWRITE}, 32'd0);
        check("midrst_paddr", PADDR, 32'd0);
        check("midrst_pwdata", PWDATA, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        do_job(0, 16'd100, 16'd23, 2'd0, 0, 1, 16'd123, 1'b0, 17, 4, b0);

`ifdef APB_ALU_SCHED_TIMEOUT_EN
        // Slave never clears VALID: four polls, then a clearing write
        do_job(0, 16'd1, 16'd2, 2'd0, 1000, 1, 16'd0, 1'b1, 29, 7, b0);
        check("to_stat_reads", 32'(count_stat(b0)), 32'd4);
        check("to_clr_wr", {31'b0, log_wr[b0+6]}, 32'd1);
        check("to_clr_addr", log_addr[b0+6], BASE + 32'h4);
        check("to_clr_data", log_data[b0+6], 32'h0);
`endif

        check("gap_between_xfers", 32'(gap_viol), 32'd0);
        check("grant_rsp_overlap", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
